// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 round-robin output multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2 for elaboration-time width sizing.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting channel at or
// after ptr, wrapping modulo N (also correct for non-power-of-two N).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 8,
    localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt,
    output logic            gnt_vld
);

    int best_off;
    int off;

    // The request with the smallest rotated distance from ptr wins.
    always_comb begin
        gnt      = '0;
        gnt_vld  = 1'b0;
        best_off = N;
        off      = 0;
        for (int i = 0; i < N; i++) begin
            if (i >= int'(ptr)) begin
                off = i - int'(ptr);
            end else begin
                off = i + N - int'(ptr);
            end
            if (req[i] && (off < best_off)) begin
                best_off = off;
                gnt      = SELW'(i);
                gnt_vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_nx1_pipe.sv
// N:1 multiplexer with fixed-select or round-robin arbitration feeding a single
// registered output stage with valid/ready handshake and full throughput.
module mux_rr_nx1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N     = 8,
    localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  arb_gnt;
    logic             arb_vld;
    logic             fixed_vld;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] word_p0;
    logic [SELW-1:0]  ptr_next;

    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  chan_p1;
    logic             vld_p1;

    rr_arbiter #(
        .N (N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_vld (arb_vld)
    );

    // An out-of-range sel simply matches no channel, so it yields no grant.
    always_comb begin
        fixed_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((sel == SELW'(i)) && in_valid[i]) begin
                fixed_vld = 1'b1;
            end
        end
    end

    always_comb begin
        grant     = (mode == MODE_RR) ? arb_gnt : sel;
        grant_vld = (mode == MODE_RR) ? arb_vld : fixed_vld;
        load_en   = !vld_p1 || out_ready;
        xfer      = load_en && grant_vld;
        ptr_next  = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
    end

    always_comb begin
        in_ready = '0;
        word_p0  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                in_ready[i] = xfer && rst_n;
                word_p0     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // ---- stage p0 -> p1: output register and round-robin pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            chan_p1 <= '0;
            vld_p1  <= 1'b0;
            rr_ptr  <= '0;
        end else begin
            if (xfer) begin
                data_p1 <= word_p0;
                chan_p1 <= grant;
                vld_p1  <= 1'b1;
                if (mode == MODE_RR) begin
                    rr_ptr <= ptr_next;
                end
            end else if (out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_rr_nx1_pipe.sv
// Self-checking bench: N=8 instance checked every cycle against a queue-free
// behavioural model, plus an N=5 instance for wrap and out-of-range select.
module tb_mux_rr_nx1_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N=8, WIDTH=16 instance
    logic [127:0] a_in_data;
    logic [7:0]   a_in_valid, a_in_ready;
    logic         a_mode, a_out_valid, a_out_ready;
    logic [2:0]   a_sel, a_out_chan;
    logic [15:0]  a_out_data;

    // N=5, WIDTH=16 instance
    logic [79:0]  b_in_data;
    logic [4:0]   b_in_valid, b_in_ready;
    logic         b_mode, b_out_valid, b_out_ready;
    logic [2:0]   b_sel, b_out_chan;
    logic [15:0]  b_out_data;

    int checks = 0;
    int failures = 0;

    mux_rr_nx1_pipe #(.WIDTH(16), .N(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .out_data(a_out_data),
        .out_chan(a_out_chan), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    mux_rr_nx1_pipe #(.WIDTH(16), .N(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .out_data(b_out_data),
        .out_chan(b_out_chan), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the N=8 instance: one held word plus a pointer.
    logic        m_vld = 1'b0;
    logic [15:0] m_data = '0;
    int          m_chan = 0;
    int          m_ptr = 0;

    function automatic int model_grant();
        if (a_mode) begin
            for (int k = 0; k < 8; k++) begin
                if (a_in_valid[(m_ptr + k) % 8]) return (m_ptr + k) % 8;
            end
            return -1;
        end
        if (a_in_valid[a_sel]) return int'(a_sel);
        return -1;
    endfunction

    function automatic logic [7:0] model_ready();
        int g;
        g = model_grant();
        if (!rst_n || g < 0 || !(!m_vld || a_out_ready)) return 8'h00;
        return 8'(1 << g);
    endfunction

    always @(negedge rst_n) begin
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_ptr  = 0;
    end

    always @(posedge clk) begin
        int g;
        if (rst_n) begin
            g = model_grant();
            if ((!m_vld || a_out_ready) && g >= 0) begin
                m_data = a_in_data[g*16 +: 16];
                m_chan = g;
                m_vld  = 1'b1;
                if (a_mode) m_ptr = (g + 1) % 8;
            end else if (m_vld && a_out_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    // Compare process: every falling edge, with inputs stable for the next rise.
    always @(negedge clk) begin
        chk("model_in_ready", 32'(a_in_ready), 32'(model_ready()));
        chk("model_out_valid", 32'(a_out_valid), 32'(m_vld));
        if (m_vld) begin
            chk("model_out_data", 32'(a_out_data), 32'(m_data));
            chk("model_out_chan", 32'(a_out_chan), 32'(m_chan));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] held;
        logic [2:0]  exp_a [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        logic [2:0]  exp_b [6]  = '{0, 1, 2, 3, 4, 0};
        logic [2:0]  exp_w [3]  = '{7, 0, 7};

        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 8'hFF; a_mode = 1'b1; a_sel = '0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = '0;    b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) b_in_data[i*16 +: 16] = 16'hB000 + 16'(i);

        step(); step();
        chk("rst_out_valid", 32'(a_out_valid), 0);
        chk("rst_out_data", 32'(a_out_data), 0);
        chk("rst_out_chan", 32'(a_out_chan), 0);
        chk("rst_in_ready", 32'(a_in_ready), 0);

        // Fixed select of channel 3
        rst_n = 1'b1;
        a_mode = 1'b0; a_sel = 3'd3; a_in_valid = 8'h08;
        a_in_data[3*16 +: 16] = 16'hBEEF;
        @(negedge clk);
        chk("fixed_in_ready", 32'(a_in_ready), 32'h08);
        step();
        chk("fixed_out_valid", 32'(a_out_valid), 1);
        chk("fixed_out_data", 32'(a_out_data), 32'hBEEF);
        chk("fixed_out_chan", 32'(a_out_chan), 3);
        a_in_valid = 8'h00;
        step();
        chk("drain_out_valid", 32'(a_out_valid), 0);

        // Round-robin over all channels, no bubbles
        a_mode = 1'b1; a_in_valid = 8'hFF;
        for (int i = 0; i < 8; i++) a_in_data[i*16 +: 16] = 16'hA000 + 16'(i);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("rr_seq_valid", 32'(a_out_valid), 1);
            chk("rr_seq_chan", 32'(a_out_chan), 32'(exp_a[k]));
        end

        // Wrap between channels 7 and 0
        a_in_valid = 8'h81;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rr_wrap_chan", 32'(a_out_chan), 32'(exp_w[k]));
        end

        // Stall with a held word
        a_in_valid = 8'hFF; a_out_ready = 1'b0;
        held = a_out_data;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(a_in_ready), 0);
            step();
            chk("stall_data", 32'(a_out_data), 32'(held));
            chk("stall_chan", 32'(a_out_chan), 7);
            chk("stall_valid", 32'(a_out_valid), 1);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(a_in_ready), 32'h01);
        step();
        chk("release_chan", 32'(a_out_chan), 0);
        chk("release_data", 32'(a_out_data), 32'hA000);

        // N=5: out-of-range select gives no grant
        b_mode = 1'b0; b_sel = 3'd7; b_in_valid = 5'h1F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_oor_in_ready", 32'(b_in_ready), 0);
            step();
            chk("b_oor_valid", 32'(b_out_valid), 0);
        end

        // N=5: round-robin wrap at a non-power-of-two count
        b_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("b_rr_chan", 32'(b_out_chan), 32'(exp_b[k]));
            chk("b_rr_data", 32'(b_out_data), 32'hB000 + 32'(exp_b[k]));
        end

        // Asynchronous reset pulse between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_a_valid", 32'(a_out_valid), 0);
        chk("async_a_data", 32'(a_out_data), 0);
        chk("async_a_ready", 32'(a_in_ready), 0);
        chk("async_b_valid", 32'(b_out_valid), 0);
        a_in_valid = 8'b0011_0100;
        b_in_valid = 5'b00101;
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_a_chan", 32'(a_out_chan), 2);
        chk("post_rst_b_chan", 32'(b_out_chan), 0);

        // Randomized traffic on the N=8 instance, checked by the model
        for (int k = 0; k < 600; k++) begin
            a_in_valid  = 8'($urandom);
            a_mode      = ($urandom_range(0, 3) != 0);
            a_sel       = 3'($urandom);
            a_out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) a_in_data[i*16 +: 16] = 16'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_nx1_pipe.md
MUX_RR_NX1_PIPE -- requirements
Module: mux_rr_nx1_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data width per channel in bits.
REQ-002 Parameter N, default 8, channel count; legal range 2..64.
REQ-003 Local parameter SELW = max(1, ceil(log2(N))), index width; not overridable.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-007 in_valid  input  N  channel i offers a word.
REQ-008 in_ready  output  N  channel i word is consumed this cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 sel  input  SELW  channel index used when mode = 0.
REQ-011 out_data  output  WIDTH  registered selected word.
REQ-012 out_chan  output  SELW  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a word.
REQ-014 out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-015 load_en = !out_valid || out_ready; the output register is written only when load_en = 1 and a grant exists.
REQ-016 Fixed mode: grant = sel when sel < N and in_valid[sel] = 1; otherwise no grant.
REQ-017 Fixed mode with sel >= N: no grant, all in_ready = 0, no error flagged.
REQ-018 Round-robin mode: grant = first i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo N; no valid channel -> no grant.
REQ-019 rr_ptr (SELW bits) updates to (grant+1) mod N only on a round-robin transfer; it holds otherwise, including in fixed mode.
REQ-020 Wrap-around: grant = N-1 -> rr_ptr = 0, also for non-power-of-two N.
REQ-021 in_ready[i] = load_en && grant exists && grant == i; at most one bit is set; the value is combinational in the same cycle.
REQ-022 Transfer: on the edge where in_ready[grant] = 1, out_data <= word of grant, out_chan <= grant, out_valid <= 1; latency is exactly one cycle.
REQ-023 out_valid clears on the edge where out_valid && out_ready && no new grant exists.
REQ-024 Simultaneous drain and load (out_valid && out_ready && grant): the new word replaces the old word in the same edge with no bubble, giving full throughput of 1 word/cycle.
REQ-025 Stall (out_valid && !out_ready): out_data and out_chan hold stable, all in_ready = 0, rr_ptr holds.
REQ-026 Changes to mode or sel take effect in the same cycle's grant; a held output word is never altered by them.
REQ-027 No combinational path from in_data to out_data; a combinational path from out_ready to in_ready is permitted.

Reset
REQ-028 Assertion of rst_n = 0 forces out_valid = 0, out_data = 0, out_chan = 0 and rr_ptr = 0 immediately, regardless of clk.
REQ-029 A word held at reset is discarded.
REQ-030 in_ready is 0 while rst_n = 0.
REQ-031 The first transfer occurs no earlier than the first rising edge after deassertion.

Structure
REQ-032 Shared package mux_pkg holds the clog2 function and the MODE_FIXED = 0 and MODE_RR = 1 constants.
REQ-033 A single sub-module rr_arbiter (N, request vector, pointer in; grant index and grant-valid out; purely combinational) implements REQ-018.
REQ-034 The top level contains the output register, rr_ptr and the handshake logic.

Verification
REQ-035 Reset, then mode = 0, sel = 3, in_valid = 8'h08, ch3 = 16'hBEEF, out_ready = 1 -> next cycle out_valid = 1, out_data = BEEF, out_chan = 3, in_ready = 8'h08 during the transfer cycle.
REQ-036 mode = 1, in_valid = 8'hFF held, out_ready = 1 for 10 cycles -> out_chan sequence 0,1,2,3,4,5,6,7,0,1 with no bubbles.
REQ-037 mode = 1, in_valid = 8'h81, rr_ptr = 1 -> grant 7, then 0, then 7 (wrap-around check); N = 5 build with in_valid = 5'h1F -> 0,1,2,3,4,0.
REQ-038 out_ready = 0 for 4 cycles with out_valid = 1 -> out_data and out_chan stable, in_ready = 0; release -> transfer resumes next edge.
REQ-039 mode = 0, sel = 7 on an N = 5 build -> no grant, out_valid stays 0; async rst_n pulse mid-stream (between edges) -> out_valid = 0 immediately, rr_ptr = 0, first post-reset round-robin grant = lowest valid channel.
